// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: splits each INPUT_WIDTH beat into up to OUTPUTS_PER_INPUT
// lanes of OUTPUT_WIDTH, one per cycle, with per-lane keep, tlast and stall support.
module axis_width_downsizer #(
  parameter int unsigned INPUT_WIDTH       = 128,
  parameter int unsigned OUTPUTS_PER_INPUT = 4,
  parameter bit          MSB_FIRST         = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        s_axis_tvalid,
  input  logic [INPUT_WIDTH-1:0]                      s_axis_tdata,
  input  logic [OUTPUTS_PER_INPUT-1:0]                s_axis_tkeep,
  input  logic                                        s_axis_tlast,
  output logic                                        s_axis_tready,
  output logic                                        m_axis_tvalid,
  output logic [INPUT_WIDTH/OUTPUTS_PER_INPUT-1:0]    m_axis_tdata,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  output logic                                        null_beat
);

  localparam int unsigned OW = INPUT_WIDTH / OUTPUTS_PER_INPUT;
  localparam int unsigned BW = INPUT_WIDTH - OW;
  localparam int unsigned CW = $clog2(OUTPUTS_PER_INPUT);

  logic          r_m_valid;
  logic [OW-1:0] r_m_data;
  logic          r_m_last;
  logic          r_null;
  logic [CW-1:0] r_lanes_left;
  logic [BW-1:0] r_buf;
  logic          r_pkt_last;

  logic [INPUT_WIDTH-1:0] w_ordered;
  logic [CW:0]            w_n;
  logic                   w_run;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_handshake;

  // Lane i of the emission order is packed at w_ordered[i*OW +: OW], so lane 0 is always the LSB slice.
  always_comb begin
    w_ordered = '0;
    for (int unsigned i = 0; i < OUTPUTS_PER_INPUT; i++) begin
      if (MSB_FIRST)
        w_ordered[i*OW +: OW] = s_axis_tdata[INPUT_WIDTH-1-i*OW -: OW];
      else
        w_ordered[i*OW +: OW] = s_axis_tdata[i*OW +: OW];
    end
  end

  // Lane count is the length of the leading run of keep bits; anything after the first gap is ignored.
  always_comb begin
    w_n   = '0;
    w_run = 1'b1;
    for (int unsigned i = 0; i < OUTPUTS_PER_INPUT; i++) begin
      if (w_run && s_axis_tkeep[i])
        w_n = (CW+1)'(i + 1);
      else
        w_run = 1'b0;
    end
  end

  assign w_s_ready   = !r_m_valid || (m_axis_tready && (r_lanes_left == '0));
  assign w_accept    = s_axis_tvalid && w_s_ready;
  assign w_handshake = r_m_valid && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_null       <= 1'b0;
      r_lanes_left <= '0;
      r_buf        <= '0;
      r_pkt_last   <= 1'b0;
    end else begin
      r_null <= 1'b0;
      if (w_accept) begin
        // An accept while valid implies the current (final) lane is handing off this cycle.
        if (w_n == '0) begin
          r_null    <= 1'b1;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end else begin
          r_m_valid    <= 1'b1;
          r_m_data     <= w_ordered[OW-1:0];
          r_buf        <= w_ordered[INPUT_WIDTH-1:OW];
          r_lanes_left <= CW'(w_n - (CW+1)'(1));
          r_m_last     <= s_axis_tlast && (w_n == (CW+1)'(1));
          r_pkt_last   <= s_axis_tlast;
        end
      end else if (w_handshake) begin
        if (r_lanes_left != '0) begin
          r_m_data     <= r_buf[OW-1:0];
          r_buf        <= r_buf >> OW;
          r_lanes_left <= r_lanes_left - CW'(1);
          r_m_last     <= r_pkt_last && (r_lanes_left == CW'(1));
        end else begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tlast  = r_m_last;
  assign null_beat     = r_null;

endmodule
